// File: rtl/mips_data_ram.sv
// Data-port RAM responder for the Harvard MIPS CPU: byte-enabled stores, waitrequest-paced loads, sticky error.
// Optional MIPS_RAM_RANDOM_STALL_EN inserts LFSR-driven single-cycle stalls before legal accesses.
module mips_data_ram #(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1
`ifdef MIPS_RAM_RANDOM_STALL_EN
    ,
    STALL   = 2'd2
`endif
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [31:0]     readdata_reg;
  logic            error_reg;

  logic [31:0]     offset;
  logic            in_range;
  logic            aligned;
  logic            legal;
  logic [ADDR_WIDTH-1:0] index;

  logic            do_write;
  logic            capture;
  logic            drive;
  logic [31:0]     drive_val;
  logic            err_set;
  logic            stall_go;
  logic [31:0]     mem_word;
  logic [31:0]     rd_word;

  // Subtracting the base first lets one shift test cover both ends of the window.
  assign offset   = address - BASE_ADDR;
  assign in_range = (address >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign aligned  = (address[1:0] == 2'b00);
  assign legal    = in_range && aligned;
  assign index    = offset[ADDR_WIDTH+1:2];

  // One RAM per byte lane so each lane infers a plain write-enabled block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (do_write && byteenable[gi])
          lane_mem[index] <= writedata[8*gi +: 8];
        if (capture)
          rd_lane_reg <= lane_mem[index];
      end

      assign mem_word[8*gi +: 8] = lane_mem[index];
      assign rd_word[8*gi +: 8]  = rd_lane_reg;
    end
  endgenerate

`ifdef MIPS_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_reg;
  logic        stalled_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg    <= 16'hACE1;
      stalled_reg <= 1'b0;
    end else begin
      lfsr_reg    <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      stalled_reg <= (state_reg == STALL);
    end
  end

  // An access that has just been stalled is never stalled a second time.
  assign stall_go = lfsr_reg[0] && !stalled_reg;
`else
  assign stall_go = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    waitrequest = 1'b0;
    do_write    = 1'b0;
    capture     = 1'b0;
    drive       = 1'b0;
    drive_val   = 32'h0;
    err_set     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (read && write) begin
          err_set = 1'b1;
        end else if ((read || write) && !legal) begin
          err_set = 1'b1;
          if (read)
            drive = 1'b1;
        end else if ((read || write) && stall_go) begin
`ifdef MIPS_RAM_RANDOM_STALL_EN
          waitrequest = 1'b1;
          state_next  = STALL;
`endif
        end else if (write) begin
          do_write = !rst;
        end else if (read) begin
          if (READ_LATENCY == 0) begin
            drive     = 1'b1;
            drive_val = mem_word;
          end else begin
            waitrequest = 1'b1;
            capture     = 1'b1;
            cnt_next    = CNT_INIT;
            state_next  = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (!read)
          err_set = 1'b1;
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          if (read) begin
            drive     = 1'b1;
            drive_val = rd_word;
          end
        end else begin
          waitrequest = 1'b1;
          cnt_next    = cnt_reg - 4'd1;
        end
      end

`ifdef MIPS_RAM_RANDOM_STALL_EN
      STALL: begin
        waitrequest = 1'b1;
        state_next  = IDLE;
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      readdata_reg <= 32'h0;
      error_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (drive)
        readdata_reg <= drive_val;
      if (err_set)
        error_reg <= 1'b1;
    end
  end

  // Valid load data bypasses the holding register so it appears in the completing cycle.
  assign readdata = drive ? drive_val : readdata_reg;
  assign error    = error_reg;

endmodule

// File: doc/mips_data_ram.md
# mips_data_ram

Data-side memory responder for the Harvard MIPS CPU: sits on the CPU's data port (address/read/write/writedata/readdata) and completes loads and stores against an internal word array. It adds a waitrequest handshake with configurable read latency, byte enables for SB/SH, and error flagging for illegal accesses. It is used both as the testbench data memory and as the on-chip data RAM in the system top level.

## Interface
- ADDR_WIDTH, 10, log2 of array depth in 32-bit words (default 1024 words = 4 KiB)
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned
- READ_LATENCY, 1, cycles of waitrequest inserted before read data returns (0..15)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- address  in  32  byte address from CPU
- read  in  1  load request
- write  in  1  store request
- writedata  in  32  store data
- byteenable  in  4  per-byte write mask; bit i gates writedata[8i+7:8i]
- waitrequest  out  1  high: request not yet accepted; master holds all inputs stable
- readdata  out  32  load data; valid in the cycle read is high and waitrequest low
- error  out  1  sticky protocol/address error flag

## Operation
- States: IDLE, RD_WAIT, (STALL with MIPS_RAM_RANDOM_STALL_EN).
- Word index = (address - BASE_ADDR) >> 2. In range iff address >= BASE_ADDR and index < 2^ADDR_WIDTH.
- Write in IDLE: waitrequest low same cycle (combinational); array updated at that clock edge for enabled bytes only. byteenable = 0: completes, no change.
- Read in IDLE, READ_LATENCY = 0: waitrequest low, readdata = array[index] combinationally.
- Read in IDLE, READ_LATENCY = N > 0: waitrequest high, go to RD_WAIT with counter = N-1; decrement each cycle; when counter = 0, drive readdata from registered array word and waitrequest low, return to IDLE next edge.
- read and write both high: illegal; neither performed, waitrequest low, error set.
- address[1:0] != 0 or out of range: access completes immediately (waitrequest low), writes dropped, reads return 32'h0, error set.
- error is sticky until rst.
- readdata holds its last driven value when not valid.
- Array contents are not cleared by rst.

## Timing
- Reset values: waitrequest 0, readdata 32'h0, error 0, state IDLE, counter 0.
- Write latency: 0 wait cycles; data visible to a read starting the following cycle.
- Read latency: request in cycle T completes in cycle T+READ_LATENCY.
- Read issued in the cycle after a write to the same word returns the new data.
- Master dropping read while in RD_WAIT: protocol violation; block completes the count, returns to IDLE, sets error.
- rst asserted during RD_WAIT: aborts read, no valid readdata, all outputs to reset values next edge.
- Back-to-back reads: new read accepted in the cycle after completion (IDLE re-entered), so throughput is one read per READ_LATENCY+1 cycles for N > 0.

## Configuration
- MIPS_RAM_RANDOM_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) advances every cycle; when a legal read or write arrives in IDLE and lfsr[0] = 1, enter STALL for one cycle with waitrequest high, then process normally from IDLE. Illegal accesses never stall.
- Undefined: no LFSR, no STALL state; timing fully deterministic as above.

## Test plan
- Reset, READ_LATENCY=1: after rst, waitrequest=0, readdata=0, error=0; SW 32'hDEADBEEF to 0x10, LW 0x10 -> waitrequest high 1 cycle, then readdata=32'hDEADBEEF.
- Byte enables: write 32'h11223344 to 0x20, then writedata=32'hAABBCCDD byteenable=4'b0101 -> read returns 32'h11BB33DD.
- Illegal: read=write=1 at 0x30 -> waitrequest low, no array change, error=1 and stays 1 through later legal accesses until rst.
- Misaligned/out-of-range: LW 0x02 and LW 0x1000 (ADDR_WIDTH=10) -> readdata=0, error=1; SW 0x1000 -> word 0 unchanged.
- Latency sweep READ_LATENCY=0,3: read completes in 0 and 3 wait cycles; rst during cycle 2 of a 3-cycle read -> no valid data, state IDLE.
- With MIPS_RAM_RANDOM_STALL_EN: 1000 random SW/LW to distinct words, compare with scoreboard -> all data match, stall cycles never exceed 1 per access, error=0.
